// File: rtl/uart_xmtr_wrapper.sv
// uart_xmtr_wrapper: FIFO-buffered UART transmitter that serialises bytes
// LSB-first at CLKS_PER_BIT clocks per bit, with STOP_BITS stop bits.
// The byte FIFO has no bypass path, and all outputs come from flops. Each
// output lags the internal FSM state by one clock.
// Optional feature: define UART_XMTR_PARITY_EN to add a parity bit between
// the data bits and the stop bits. The parity is even by default; the
// tx_parity_odd input selects odd parity for each frame.
module uart_xmtr_wrapper #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
`ifdef UART_XMTR_PARITY_EN
  input  logic                              tx_parity_odd,
`endif
  output logic                              tx_ready,
  output logic                              uart_sout,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              frame_done
);

  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_XMTR_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ready_q, ready_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       shift_q, shift_d;
`ifdef UART_XMTR_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             push, pop, bit_end;

  assign tx_ready   = ready_q;
  assign uart_sout  = sout_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;
  assign frame_done = done_q;

  // Next-state logic: FSM sequencing, FIFO bookkeeping and the registered outputs.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_XMTR_PARITY_EN
    parity_d  = parity_q;
`endif
    pop       = 1'b0;
    push      = tx_valid && ready_q;
    bit_end   = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          clk_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_XMTR_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_XMTR_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            // Chain straight into the next frame when data is waiting.
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
`ifdef UART_XMTR_PARITY_EN
      parity_d = (^mem_q[rd_ptr_q]) ^ tx_parity_odd;
`endif
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < CW'(FIFO_DEPTH));

    // The line level follows the current state, so it trails the state by one clock.
    case (state_q)
      S_START: sout_d = 1'b0;
      S_DATA:  sout_d = shift_q[0];
`ifdef UART_XMTR_PARITY_EN
      S_PARITY: sout_d = parity_q;
`endif
      default: sout_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_STOP) && bit_end && (bit_idx_q == 3'(STOP_BITS - 1));
  end

  // Control state and outputs; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ready_q   <= 1'b1;
      sout_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ready_q   <= ready_d;
      sout_q    <= sout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Datapath registers: these need no reset because the FSM never reads them before loading them.
  always_ff @(posedge clock) begin
    shift_q  <= shift_d;
`ifdef UART_XMTR_PARITY_EN
    parity_q <= parity_d;
`endif
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_xmtr_wrapper.sv
// tb_uart_xmtr_wrapper: directed bench for uart_xmtr_wrapper. It covers the
// idle line after reset, single and back-to-back frames, a full FIFO, reset
// in the middle of a frame and, with UART_XMTR_PARITY_EN, the parity bit.
module tb_uart_xmtr_wrapper;

  localparam int CLKS  = 4;
  localparam int DEPTH = 4;
`ifdef UART_XMTR_PARITY_EN
  localparam int PAR   = 1;
  localparam int STOPB = 2;
`else
  localparam int PAR   = 0;
  localparam int STOPB = 1;
`endif
  localparam int NBITS = 10 + PAR + STOPB - 1;

  logic       clock;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef UART_XMTR_PARITY_EN
  logic       tx_parity_odd;
`endif
  logic       tx_ready;
  logic       uart_sout;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

  uart_xmtr_wrapper #(
    .CLKS_PER_BIT(CLKS),
    .FIFO_DEPTH  (DEPTH),
    .STOP_BITS   (STOPB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
`ifdef UART_XMTR_PARITY_EN
    .tx_parity_odd(tx_parity_odd),
`endif
    .tx_ready     (tx_ready),
    .uart_sout    (uart_sout),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count),
    .frame_done   (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Poll at falling edges until the line drops, for at most 'budget' clocks.
  task automatic wait_start(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (uart_sout === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("start_seen", found, 1);
  endtask

  // Entered on the first start-bit clock; leaves on the last stop-bit clock.
  task automatic check_frame(input logic [7:0] b, input logic par);
    logic [7:0] dec = 8'h00;
    int nc = NBITS * CLKS;
    for (int c = 0; c < nc; c++) begin
      int   bi = c / CLKS;
      logic e;
      if (bi == 0)                   e = 1'b0;
      else if (bi <= 8)              e = b[bi-1];
      else if (PAR != 0 && bi == 9)  e = par;
      else                           e = 1'b1;
      check("sout", uart_sout, e);
      check("busy", tx_busy, 1);
      check("frame_done", frame_done, (c == nc - 1));
      if (bi >= 1 && bi <= 8 && (c % CLKS) == CLKS / 2) dec[bi-1] = uart_sout;
      if (c != nc - 1) @(negedge clock);
    end
    check("decoded_byte", dec, b);
  endtask

  logic [7:0] fill_bytes [8] = '{8'h01, 8'h80, 8'hC3, 8'h5A, 8'hF0, 8'h0F, 8'h99, 8'h66};
  logic       fill_par   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
`ifdef UART_XMTR_PARITY_EN
    tx_parity_odd = 1'b0;
`endif

    // Reset values and an idle line for 100 clocks.
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("rst_state", {uart_sout, tx_busy, tx_ready, fifo_count, frame_done}, 7'b1010000);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check("idle_line", {uart_sout, tx_busy, tx_ready, fifo_count, frame_done}, 7'b1010000);
    end

    // Single frame 0x55: line falls two edges after the push.
    @(negedge clock);
    tx_data = 8'h55; tx_valid = 1'b1;
    @(posedge clock); #1 tx_valid = 1'b0;
    @(negedge clock);
    check("single_cnt_after_push", fifo_count, 1);
    check("single_sout_e1", uart_sout, 1);
    check("single_busy_e1", tx_busy, 0);
    @(negedge clock);
    check("single_sout_e2", uart_sout, 1);
    check("single_cnt_after_pop", fifo_count, 0);
    check("single_busy_e2", tx_busy, 0);
    @(negedge clock);
    check_frame(8'h55, 1'b0);
    @(negedge clock);
    check("single_busy_after", tx_busy, 0);
    check("single_sout_after", uart_sout, 1);
    check("single_done_after", frame_done, 0);

    // Back-to-back frames with no idle gap.
    repeat (3) @(negedge clock);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("b2b_cnt1", fifo_count, 1);
    tx_data = 8'h3C;
    @(posedge clock);
    @(negedge clock);
    check("b2b_cnt2", fifo_count, 1);
    tx_data = 8'hFF;
    @(posedge clock);
    @(negedge clock);
    tx_valid = 1'b0;
    check("b2b_cnt3", fifo_count, 2);
    check_frame(8'hA5, 1'b0);
    @(negedge clock);
    check("b2b_cnt_f2", fifo_count, 1);
    check_frame(8'h3C, 1'b0);
    @(negedge clock);
    check("b2b_cnt_f3", fifo_count, 0);
    check_frame(8'hFF, 1'b0);
    @(negedge clock);
    check("b2b_idle_busy", tx_busy, 0);
    check("b2b_idle_cnt", fifo_count, 0);

    // Full FIFO: hold tx_valid with 8 bytes against a slow line.
    repeat (3) @(negedge clock);
    fork
      begin
        int idx  = 0;
        int cyc  = 0;
        int maxc = 0;
        while (idx < 8 && cyc < 2000) begin
          logic acc;
          @(negedge clock);
          tx_data  = fill_bytes[idx];
          tx_valid = 1'b1;
          check("full_ready_vs_count", tx_ready, (fifo_count < 3'(DEPTH)));
          if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
          acc = tx_ready;
          @(posedge clock);
          if (acc) idx++;
          cyc++;
        end
        #1 tx_valid = 1'b0;
        check("full_max_count", maxc, 4);
        check("full_pushed", idx, 8);
      end
      begin
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          wait_start(400);
          check_frame(fill_bytes[i], fill_par[i]);
          @(negedge clock);
        end
      end
    join
    check("full_drained", fifo_count, 0);
    check("full_idle", tx_busy, 0);

    // Reset during data bit 3 of 0x00 with 2 bytes queued.
    repeat (3) @(negedge clock);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    tx_data = 8'hAA;
    @(posedge clock);
    @(negedge clock);
    tx_data = 8'hBB;
    @(posedge clock);
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (17) @(negedge clock);
    check("rmid_sout_bit3", uart_sout, 0);
    check("rmid_cnt_before", fifo_count, 2);
    check("rmid_busy_before", tx_busy, 1);
    #1 reset = 1'b1;
    #1;
    check("rmid_sout_now", uart_sout, 1);
    check("rmid_cnt_now", fifo_count, 0);
    check("rmid_busy_now", tx_busy, 0);
    check("rmid_ready_now", tx_ready, 1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    begin
      int activity = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clock);
        if (uart_sout !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0) activity++;
      end
      check("rmid_no_frames", activity, 0);
    end

`ifdef UART_XMTR_PARITY_EN
    // Even parity: 0x07 -> 1, 0x55 -> 0; odd parity: 0x07 -> 0.
    @(negedge clock);
    tx_parity_odd = 1'b0;
    tx_data = 8'h07; tx_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    tx_data = 8'h55;
    @(posedge clock); #1 tx_valid = 1'b0;
    @(negedge clock);
    wait_start(20);
    check_frame(8'h07, 1'b1);
    @(negedge clock);
    check_frame(8'h55, 1'b0);
    @(negedge clock);
    check("par_idle", tx_busy, 0);
    repeat (3) @(negedge clock);
    tx_parity_odd = 1'b1;
    tx_data = 8'h07; tx_valid = 1'b1;
    @(posedge clock); #1 tx_valid = 1'b0;
    @(negedge clock);
    wait_start(20);
    tx_parity_odd = 1'b0;
    check_frame(8'h07, 1'b0);
    @(negedge clock);
    check("par_odd_idle", tx_busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_xmtr_wrapper.md
Name: uart_xmtr_wrapper

Overview:
- Bench-side UART transmitter: drives serial 8N1 frames into the DUT's UART receive pin (uart_pl_rxd side).
- Opposite end of the bench UART receiver/monitor.
- Bytes are pushed through a valid/ready interface, buffered in an internal FIFO, and serialised LSB-first at a fixed number of clocks per bit.
- Synthesizable RTL; it can also be reused as a PL-side loopback stimulus.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 16: byte FIFO entries; power of two, 2..256.
- STOP_BITS, 1: number of stop bits per frame; 1 or 2.

Ports:
- clock, input, 1: sole clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- tx_data, input, 8: byte to enqueue.
- tx_valid, input, 1: tx_data valid.
- tx_ready, output, 1: FIFO can accept a byte this cycle.
- uart_sout, output, 1: serial line to the DUT rxd; idles high.
- tx_busy, output, 1: high while a frame is on the line, start bit through last stop bit.
- fifo_count, output, clog2(FIFO_DEPTH+1): bytes currently buffered, excluding the byte being shifted.
- frame_done, output, 1: one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset values, applied immediately on reset assertion:
  - uart_sout=1, tx_ready=1, tx_busy=0, fifo_count=0, frame_done=0.
  - FSM=IDLE; FIFO pointers and bit/clock counters cleared.
- Reset mid-frame: the frame is aborted, the line returns high at once, and buffered bytes are discarded.
- Push:
  - A byte is written when tx_valid && tx_ready at a clock edge.
  - tx_ready = (fifo_count < FIFO_DEPTH), registered from the count.
  - A push while full cannot occur because tx_ready is low; no overflow state exists.
- Pop: the FSM pops only from IDLE or STOP (see below), and only when fifo_count > 0.
- Simultaneous push and pop in one cycle: fifo_count is unchanged and both operations take effect.
- No bypass path: a byte pushed into an empty FIFO at edge N is popped at edge N+1, and uart_sout falls at edge N+2.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE:
  - uart_sout=1.
  - If fifo_count>0: pop, load the shift register, clear the clock counter, go to START.
- START: uart_sout=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - uart_sout = shift_reg[0] for CLKS_PER_BIT cycles, then shift right and increment the index.
  - After index 7 completes, go to PARITY if enabled, else STOP.
- STOP:
  - uart_sout=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle, frame_done pulses.
  - If the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle cycle); otherwise go to IDLE.
- tx_busy: high in START, DATA, PARITY and STOP; low in IDLE.
- Frame length: (10 + parity + STOP_BITS - 1) * CLKS_PER_BIT clocks exactly.
- Clock counter: width clog2(CLKS_PER_BIT); wraps to 0 at CLKS_PER_BIT-1. The bit-index counter is 3 bits.
- uart_sout is driven from a flop; it never glitches combinationally.

Optional Feature:
- Macro: UART_XMTR_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Parity is even: the XOR of the 8 data bits. The frame becomes 8E1/8E2.
  - An extra input tx_parity_odd (1 bit, sampled in IDLE/STOP at pop) selects odd parity per frame.
- Not defined: no PARITY state, no tx_parity_odd port; frames are 8N1/8N2.

Test Plan:
- Reset line idle: assert reset for 5 clocks then release, no pushes -> uart_sout=1, tx_busy=0, tx_ready=1, fifo_count=0 for 100 clocks.
- Single frame: CLKS_PER_BIT=4, push 0x55 -> starting 2 edges after the push, line shows 0,1,0,1,0,1,0,1,0,1, each level held 4 clocks. frame_done pulses at clock 40 of the frame and tx_busy is high for exactly 40 clocks.
- Back-to-back: push 0xA5,0x3C,0xFF in consecutive cycles -> three frames with no idle gap between the stop bit and the next start bit. fifo_count sequence after pushes is 1,1,2, draining to 0. Decoded bytes match in order.
- Full FIFO: FIFO_DEPTH=4, hold tx_valid high with 8 bytes while the line is slow -> tx_ready drops when fifo_count=4, no byte is lost or duplicated, and all 8 bytes are serialised in order.
- Reset mid-frame: assert reset during data bit 3 of 0x00 with 2 bytes queued -> uart_sout=1 in the same cycle, fifo_count=0. After release, no further frames appear.
- Parity (UART_XMTR_PARITY_EN, STOP_BITS=2): push 0x07 then 0x55 -> parity bits 1 then 0. Each frame is 12*CLKS_PER_BIT clocks long. With tx_parity_odd=1, 0x07 gives parity 0.
